// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
//   EX-stage operand forwarding selects for NSRC sources (EX/MEM beats MEM/WB)
//   plus a load-use hazard detector whose stall FSM holds PC/IF-ID and
//   bubbles ID/EX for LOAD_LAT cycles per hazard.
//   Optional build macro: HFU_STATS_EN -- adds saturating 16-bit counters on
//   STATS ({hazard detections, forwarding cycles}); without it STATS is 0.

// Per-operand slice: forwarding select for the EX-stage source, plus the
// address match of the ID-stage source against the in-flight load.
module hfu_fwd_lane #(
  parameter int AW = 5
) (
  input  logic [AW-1:0] ars,
  input  logic [AW-1:0] ars_id,
  input  logic [AW-1:0] ard_id_ex,
  input  logic [AW-1:0] ard_ex_mem,
  input  logic          regwrite_ex_mem,
  input  logic [AW-1:0] ard_mem_wb,
  input  logic          regwrite_mem_wb,
  output logic [1:0]    sel,
  output logic          load_hit
);
  logic hit_mem, hit_wb;

  // x0 is hard-wired zero, so a write to it must never be forwarded
  assign hit_mem  = regwrite_ex_mem && (ard_ex_mem != '0) && (ard_ex_mem == ars);
  assign hit_wb   = regwrite_mem_wb && (ard_mem_wb != '0) && (ard_mem_wb == ars);
  assign load_hit = (ard_id_ex == ars_id);

  // EX/MEM carries the younger result, so it takes priority over MEM/WB
  always_comb begin
    sel = 2'b00;
    if (hit_mem)     sel = 2'b10;
    else if (hit_wb) sel = 2'b01;
  end
endmodule

module hazard_forward_unit #(
  parameter int AW       = 5,
  parameter int NSRC     = 2,
  parameter int LOAD_LAT = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NSRC*AW-1:0]   ARS,
  input  logic [NSRC*AW-1:0]   ARS_IF_ID,
  input  logic [AW-1:0]        ARD_ID_EX,
  input  logic                 MEMREAD_ID_EX,
  input  logic [AW-1:0]        ARD_EX_MEM,
  input  logic                 REGWRITE_EX_MEM,
  input  logic [AW-1:0]        ARD_MEM_WB,
  input  logic                 REGWRITE_MEM_WB,
  output logic [2*NSRC-1:0]    FORWARD,
  output logic                 STALL,
  output logic                 BUBBLE,
  output logic [31:0]          STATS
);
  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] STALLING = 1'b1;
  // detection cycle is the first stall cycle, the counter covers the rest
  localparam logic [2:0] CNT_INIT = 3'(LOAD_LAT - 1);
  localparam bit         MULTI    = (LOAD_LAT > 1);

  logic [NSRC-1:0][1:0] fwd_sel;
  logic [NSRC-1:0]      load_hit;
  logic                 haz;
  logic [0:0]           state;
  logic [2:0]           cnt;

  for (genvar i = 0; i < NSRC; i++) begin : g_lane
    hfu_fwd_lane #(.AW(AW)) u_lane (
      .ars             (ARS[i*AW +: AW]),
      .ars_id          (ARS_IF_ID[i*AW +: AW]),
      .ard_id_ex       (ARD_ID_EX),
      .ard_ex_mem      (ARD_EX_MEM),
      .regwrite_ex_mem (REGWRITE_EX_MEM),
      .ard_mem_wb      (ARD_MEM_WB),
      .regwrite_mem_wb (REGWRITE_MEM_WB),
      .sel             (fwd_sel[i]),
      .load_hit        (load_hit[i])
    );
  end

  assign haz = MEMREAD_ID_EX && (ARD_ID_EX != '0) && (|load_hit);

  // stall FSM: a hazard seen in IDLE stalls that cycle; longer loads park in
  // STALLING and count down the remaining cycles, ignoring HAZ meanwhile
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (state == IDLE) begin
      if (haz && MULTI) begin
        state <= STALLING;
        cnt   <= CNT_INIT;
      end
    end else begin
      if (cnt == 3'd1) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        cnt <= cnt - 3'd1;
      end
    end
  end

  // reset masks every output combinationally, including a stall in progress
  always_comb begin
    FORWARD = RST ? '0 : fwd_sel;
    STALL   = !RST && ((state == STALLING) || haz);
    BUBBLE  = STALL;
  end

`ifdef HFU_STATS_EN
  logic [15:0] fwd_cnt, haz_cnt;
  logic        any_fwd, haz_entry;

  assign any_fwd   = |fwd_sel;
  assign haz_entry = (state == IDLE) && haz;

  // saturating event counters; they stick at all-ones rather than wrapping
  always_ff @(posedge CLK) begin
    if (RST) begin
      fwd_cnt <= '0;
      haz_cnt <= '0;
    end else begin
      if (any_fwd && (fwd_cnt != 16'hFFFF))   fwd_cnt <= fwd_cnt + 16'd1;
      if (haz_entry && (haz_cnt != 16'hFFFF)) haz_cnt <= haz_cnt + 16'd1;
    end
  end

  assign STATS = RST ? 32'd0 : {haz_cnt, fwd_cnt};
`else
  assign STATS = 32'd0;
`endif
endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: two instances (NSRC=2/LOAD_LAT=1 and
// NSRC=3/LOAD_LAT=3) share stimulus; a stall-countdown reference model
// predicts every output. Build with +define+HFU_STATS_EN to check counters.
module tb_hazard_forward_unit;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
`ifdef HFU_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic [14:0] ars, ars_if_id;
  logic [4:0]  ard_id_ex, ard_ex_mem, ard_mem_wb;
  logic        memread, rw_mem, rw_wb;
  logic [3:0]  fwd_a;
  logic [5:0]  fwd_b;
  logic        stall_a, bubble_a, stall_b, bubble_b;
  logic [31:0] stats_a, stats_b;

  int vectors = 0;
  int errors  = 0;

  int rem_a = 0, rem_b = 0;
  int fcnt_a = 0, hcnt_a = 0, fcnt_b = 0, hcnt_b = 0;

  always #5 CLK = ~CLK;

  hazard_forward_unit #(.AW(5), .NSRC(2), .LOAD_LAT(LAT_A)) dut_a (
    .CLK(CLK), .RST(RST), .ARS(ars[9:0]), .ARS_IF_ID(ars_if_id[9:0]),
    .ARD_ID_EX(ard_id_ex), .MEMREAD_ID_EX(memread),
    .ARD_EX_MEM(ard_ex_mem), .REGWRITE_EX_MEM(rw_mem),
    .ARD_MEM_WB(ard_mem_wb), .REGWRITE_MEM_WB(rw_wb),
    .FORWARD(fwd_a), .STALL(stall_a), .BUBBLE(bubble_a), .STATS(stats_a));

  hazard_forward_unit #(.AW(5), .NSRC(3), .LOAD_LAT(LAT_B)) dut_b (
    .CLK(CLK), .RST(RST), .ARS(ars), .ARS_IF_ID(ars_if_id),
    .ARD_ID_EX(ard_id_ex), .MEMREAD_ID_EX(memread),
    .ARD_EX_MEM(ard_ex_mem), .REGWRITE_EX_MEM(rw_mem),
    .ARD_MEM_WB(ard_mem_wb), .REGWRITE_MEM_WB(rw_wb),
    .FORWARD(fwd_b), .STALL(stall_b), .BUBBLE(bubble_b), .STATS(stats_b));

  // ---------------- reference model ----------------
  function automatic logic [5:0] m_fwd(input int n);
    logic [5:0] r;
    logic [4:0] s;
    r = '0;
    if (RST) return r;
    for (int i = 0; i < n; i++) begin
      s = ars[i*5 +: 5];
      if (rw_mem && ard_ex_mem != 0 && ard_ex_mem == s)   r[2*i +: 2] = 2'b10;
      else if (rw_wb && ard_mem_wb != 0 && ard_mem_wb == s) r[2*i +: 2] = 2'b01;
    end
    return r;
  endfunction

  function automatic bit m_haz(input int n);
    bit h;
    h = 1'b0;
    for (int i = 0; i < n; i++)
      if (ars_if_id[i*5 +: 5] == ard_id_ex) h = 1'b1;
    return memread && ard_id_ex != 0 && h;
  endfunction

  // remaining = forced stall cycles still owed after the detection cycle
  function automatic bit m_stall(input int remaining, input int n);
    return !RST && (remaining > 0 || m_haz(n));
  endfunction

  function automatic logic [31:0] m_stats(input int f, input int h);
    if (!STATS_ON || RST) return 32'd0;
    return {16'(h), 16'(f)};
  endfunction

  // model state advances on the same edge as the DUT
  always @(posedge CLK) begin
    if (RST) begin
      rem_a <= 0; rem_b <= 0;
      fcnt_a <= 0; hcnt_a <= 0; fcnt_b <= 0; hcnt_b <= 0;
    end else begin
      rem_a <= (rem_a > 0) ? rem_a - 1 : (m_haz(2) ? LAT_A - 1 : 0);
      rem_b <= (rem_b > 0) ? rem_b - 1 : (m_haz(3) ? LAT_B - 1 : 0);
      if (m_fwd(2) != 0 && fcnt_a < 65535) fcnt_a <= fcnt_a + 1;
      if (m_fwd(3) != 0 && fcnt_b < 65535) fcnt_b <= fcnt_b + 1;
      if (rem_a == 0 && m_haz(2) && hcnt_a < 65535) hcnt_a <= hcnt_a + 1;
      if (rem_b == 0 && m_haz(3) && hcnt_b < 65535) hcnt_b <= hcnt_b + 1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_inputs();
    ars = '0; ars_if_id = '0; ard_id_ex = '0; ard_ex_mem = '0; ard_mem_wb = '0;
    memread = 1'b0; rw_mem = 1'b0; rw_wb = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge CLK); #1;
  endtask

  task automatic idle(input int n);
    clear_inputs();
    for (int k = 0; k < n; k++) next_cycle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST = 1'b1;
    ars = 15'h1234; ars_if_id = 15'h1234; ard_id_ex = 5'd4; memread = 1'b1;
    ard_ex_mem = 5'd4; rw_mem = 1'b1; ard_mem_wb = 5'd13; rw_wb = 1'b1;
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      @(negedge CLK);
      vectors++;
      if ({fwd_a, fwd_b, stall_a, bubble_a, stall_b, bubble_b} !== 14'd0) begin
        errors++; $display("FAIL reset_ctl: got fwd_a=%b fwd_b=%b st=%b%b%b%b want all 0",
                           fwd_a, fwd_b, stall_a, bubble_a, stall_b, bubble_b);
      end
      vectors++;
      if (stats_a !== 32'd0 || stats_b !== 32'd0) begin
        errors++; $display("FAIL reset_stats: got %h/%h want 0", stats_a, stats_b);
      end
    end
    next_cycle();
    RST = 1'b0;
    idle(1);
  endtask

  task automatic test_forward_basic();
    clear_inputs();
    ars[4:0] = 5'd3; ars[9:5] = 5'd4;
    ard_ex_mem = 5'd3; rw_mem = 1'b1; ard_mem_wb = 5'd4; rw_wb = 1'b1;
    @(negedge CLK);
    vectors++;
    if (fwd_a !== 4'b0110) begin
      errors++; $display("FAIL fwd_basic_a: got %b want 0110", fwd_a);
    end
    vectors++;
    if (fwd_b !== 6'b000110) begin
      errors++; $display("FAIL fwd_basic_b: got %b want 000110", fwd_b);
    end
    ars[14:10] = 5'd4;
    #1;
    vectors++;
    if (fwd_b !== 6'b010110) begin
      errors++; $display("FAIL fwd_op2_b: got %b want 010110", fwd_b);
    end
    next_cycle();
  endtask

  task automatic test_priority_zero();
    clear_inputs();
    ars[4:0] = 5'd7; ard_ex_mem = 5'd7; ard_mem_wb = 5'd7; rw_mem = 1'b1; rw_wb = 1'b1;
    @(negedge CLK);
    vectors++;
    if (fwd_a[1:0] !== 2'b10) begin
      errors++; $display("FAIL fwd_priority: got %b want 10", fwd_a[1:0]);
    end
    next_cycle();
    ars[4:0] = 5'd0; ard_ex_mem = 5'd0; ard_mem_wb = 5'd0;
    @(negedge CLK);
    vectors++;
    if (fwd_a !== 4'b0000) begin
      errors++; $display("FAIL fwd_x0: got %b want 0000", fwd_a);
    end
    // write to x0 on EX/MEM must not mask a valid MEM/WB match
    next_cycle();
    ars[9:5] = 5'd0; ard_mem_wb = 5'd0; ars[4:0] = 5'd0;
    ard_ex_mem = 5'd0; rw_mem = 1'b1;
    ars[9:5] = 5'd5; ard_mem_wb = 5'd5;
    @(negedge CLK);
    vectors++;
    if (fwd_a !== 4'b0100) begin
      errors++; $display("FAIL fwd_wb_only: got %b want 0100", fwd_a);
    end
    next_cycle();
  endtask

  task automatic test_stall_lat1();
    idle(4);
    memread = 1'b1; ard_id_ex = 5'd9; ars_if_id[9:5] = 5'd9;
    @(negedge CLK);
    vectors++;
    if (stall_a !== 1'b1 || bubble_a !== 1'b1) begin
      errors++; $display("FAIL lat1_stall: got %b%b want 11", stall_a, bubble_a);
    end
    next_cycle();
    memread = 1'b0;
    @(negedge CLK);
    vectors++;
    if (stall_a !== 1'b0 || bubble_a !== 1'b0) begin
      errors++; $display("FAIL lat1_release: got %b%b want 00", stall_a, bubble_a);
    end
    idle(4);
  endtask

  task automatic test_back_to_back();
    logic [6:0] seen;
    idle(4);
    seen = '0;
    memread = 1'b1; ard_id_ex = 5'd9; ars_if_id[9:5] = 5'd9;
    for (int k = 0; k < 7; k++) begin
      if (k == 3) begin
        ard_id_ex = 5'd10; ars_if_id[9:5] = 5'd0; ars_if_id[14:10] = 5'd10;
      end
      if (k == 4) memread = 1'b0;
      @(negedge CLK);
      seen[k] = stall_b & bubble_b;
      next_cycle();
    end
    vectors++;
    if (seen !== 7'b0111111) begin
      errors++; $display("FAIL back_to_back: got stall trace %b want 0111111", seen);
    end
    idle(2);
  endtask

  task automatic test_reset_mid_stall();
    idle(4);
    memread = 1'b1; ard_id_ex = 5'd9; ars_if_id[4:0] = 5'd9;
    ars[4:0] = 5'd2; ard_ex_mem = 5'd2; rw_mem = 1'b1;
    @(negedge CLK);
    vectors++;
    if (stall_b !== 1'b1) begin
      errors++; $display("FAIL midrst_first: got %b want 1", stall_b);
    end
    next_cycle();
    RST = 1'b1;
    @(negedge CLK);
    vectors++;
    if (stall_b !== 1'b0 || bubble_b !== 1'b0 || fwd_b !== 6'd0) begin
      errors++; $display("FAIL midrst_cycle: got st=%b bb=%b fwd=%b want 0 0 000000",
                         stall_b, bubble_b, fwd_b);
    end
    next_cycle();
    RST = 1'b0; memread = 1'b0;
    @(negedge CLK);
    vectors++;
    if (stall_b !== 1'b0) begin
      errors++; $display("FAIL midrst_idle: got %b want 0", stall_b);
    end
    idle(2);
  endtask

  task automatic test_random();
    logic [5:0]  ef_a, ef_b;
    logic [31:0] es_a, es_b;
    for (int k = 0; k < 500; k++) begin
      RST        = ($urandom_range(0, 39) == 0);
      memread    = 1'($urandom_range(0, 1));
      rw_mem     = 1'($urandom_range(0, 1));
      rw_wb      = 1'($urandom_range(0, 1));
      ard_id_ex  = 5'($urandom_range(0, 7));
      ard_ex_mem = 5'($urandom_range(0, 7));
      ard_mem_wb = 5'($urandom_range(0, 7));
      for (int i = 0; i < 3; i++) begin
        ars[i*5 +: 5]       = 5'($urandom_range(0, 7));
        ars_if_id[i*5 +: 5] = 5'($urandom_range(0, 7));
      end
      @(negedge CLK);
      ef_a = m_fwd(2); ef_b = m_fwd(3);
      es_a = m_stats(fcnt_a, hcnt_a); es_b = m_stats(fcnt_b, hcnt_b);
      vectors++;
      if (fwd_a !== ef_a[3:0]) begin
        errors++; $display("FAIL rnd_fwd_a @%0d: got %b want %b", k, fwd_a, ef_a[3:0]);
      end
      vectors++;
      if (fwd_b !== ef_b) begin
        errors++; $display("FAIL rnd_fwd_b @%0d: got %b want %b", k, fwd_b, ef_b);
      end
      vectors++;
      if (stall_a !== m_stall(rem_a, 2) || bubble_a !== m_stall(rem_a, 2)) begin
        errors++; $display("FAIL rnd_stall_a @%0d: got %b%b want %b", k, stall_a, bubble_a, m_stall(rem_a, 2));
      end
      vectors++;
      if (stall_b !== m_stall(rem_b, 3) || bubble_b !== m_stall(rem_b, 3)) begin
        errors++; $display("FAIL rnd_stall_b @%0d: got %b%b want %b", k, stall_b, bubble_b, m_stall(rem_b, 3));
      end
      vectors++;
      if (stats_a !== es_a || stats_b !== es_b) begin
        errors++; $display("FAIL rnd_stats @%0d: got %h/%h want %h/%h", k, stats_a, stats_b, es_a, es_b);
      end
      next_cycle();
    end
    RST = 1'b0;
    idle(4);
  endtask

  task automatic test_stats();
    logic [31:0] es_b;
    RST = 1'b1;
    clear_inputs();
    next_cycle();
    RST = 1'b0;
    ars[4:0] = 5'd3; ard_ex_mem = 5'd3; rw_mem = 1'b1;
    for (int k = 0; k < 5; k++) next_cycle();
    clear_inputs();
    for (int k = 0; k < 2; k++) begin
      memread = 1'b1; ard_id_ex = 5'd9; ars_if_id[9:5] = 5'd9;
      next_cycle();
      clear_inputs();
      next_cycle();
    end
    @(negedge CLK);
    vectors++;
    if (stats_a !== (STATS_ON ? 32'h0002_0005 : 32'd0)) begin
      errors++; $display("FAIL stats_directed: got %h want %h", stats_a,
                         STATS_ON ? 32'h0002_0005 : 32'd0);
    end
`ifdef HFU_STATS_EN
    ars[4:0] = 5'd3; ard_ex_mem = 5'd3; rw_mem = 1'b1;
    for (int k = 0; k < 70000; k++) next_cycle();
    @(negedge CLK);
    vectors++;
    if (stats_a !== 32'h0002_FFFF) begin
      errors++; $display("FAIL stats_saturate: got %h want 0002ffff", stats_a);
    end
    es_b = m_stats(fcnt_b, hcnt_b);
    vectors++;
    if (stats_b !== es_b || es_b[15:0] !== 16'hFFFF) begin
      errors++; $display("FAIL stats_saturate_b: got %h want %h", stats_b, es_b);
    end
`else
    es_b = m_stats(fcnt_b, hcnt_b);
    vectors++;
    if (stats_b !== es_b) begin
      errors++; $display("FAIL stats_off_b: got %h want %h", stats_b, es_b);
    end
`endif
    idle(2);
  endtask

  initial begin
    RST = 1'b1;
    clear_inputs();
    test_reset();
    test_forward_basic();
    test_priority_zero();
    test_stall_lat1();
    test_back_to_back();
    test_reset_mid_stall();
    test_random();
    test_stats();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
